// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants and state type for the execute stage.
package ex_pkg;

   localparam int MUL_CYCLES = 8;
   localparam int PC_W       = 32;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MULT = 6'h18;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_MUL_DONE = 2'd2
   } ex_state_e;

endpackage

// File: rtl/ex_mul8.sv
// rtl/ex_mul8.sv - iterative shift-add multiplier, one multiplier bit per cycle.
module ex_mul8
   import ex_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] product_o
);

   logic [7:0] mcand_q, mplier_q, acc_q;
   logic [2:0] cnt_q;
   logic       busy_q;

   // done_o marks the cycle doing the final iteration; acc_q is complete after it.
   assign done_o    = busy_q && (cnt_q == 3'(MUL_CYCLES - 1));
   assign busy_o    = busy_q;
   assign product_o = acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= 8'h00;
         mplier_q <= 8'h00;
         acc_q    <= 8'h00;
         cnt_q    <= 3'd0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= 8'h00;
         cnt_q    <= 3'd0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[cnt_q]) acc_q <= acc_q + (mcand_q << cnt_q);
         cnt_q <= cnt_q + 3'd1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch/jump redirect, EX/MEM register.
// EX_MULT_EN enables the iterative multiplier, its FSM and the stall output.
module ex_stage
   import ex_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      EX_read_data1,
   input  logic [7:0]      EX_read_data2,
   input  logic [31:0]     EX_instruction,
   input  logic [PC_W-1:0] EX_pcplus4,
   input  logic [1:0]      EX_ALUOp,
   input  logic            EX_ALUSrc,
   input  logic            EX_RegDst,
   input  logic            EX_Branch,
   input  logic            EX_BranchFlip,
   input  logic            EX_Jump,
   input  logic            EX_MemRead,
   input  logic            EX_MemWrite,
   input  logic            EX_RegWrite,
   input  logic            EX_MemtoReg,
   output logic            ex_stall,
   output logic [7:0]      MEM_alu_result,
   output logic [7:0]      MEM_write_data,
   output logic [4:0]      MEM_write_reg,
   output logic            MEM_MemRead,
   output logic            MEM_MemWrite,
   output logic            MEM_RegWrite,
   output logic            MEM_MemtoReg,
   output logic            MEM_pc_redirect,
   output logic [PC_W-1:0] MEM_pc_target
);

   logic [5:0]      funct;
   logic [7:0]      alu_b, alu_res;
   logic            is_mult, zero, taken, redirect;
   logic [PC_W-1:0] br_target, j_target, target;
   logic [4:0]      wr;
   logic            unused_instr_bits;

   assign unused_instr_bits = ^{EX_instruction[31:26], EX_instruction[10:6]};

   assign funct   = EX_instruction[5:0];
   assign alu_b   = EX_ALUSrc ? EX_instruction[7:0] : EX_read_data2;
   assign is_mult = (EX_ALUOp == ALUOP_RTYPE) && (funct == FUNCT_MULT);

   always_comb begin
      alu_res = 8'h00;
      case (EX_ALUOp)
         ALUOP_SUB:   alu_res = EX_read_data1 - alu_b;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_res = EX_read_data1 + alu_b;
               FUNCT_SUB: alu_res = EX_read_data1 - alu_b;
               FUNCT_AND: alu_res = EX_read_data1 & alu_b;
               FUNCT_OR:  alu_res = EX_read_data1 | alu_b;
               FUNCT_SLT: alu_res = {7'b0, $signed(EX_read_data1) < $signed(alu_b)};
               default:   alu_res = 8'h00;
            endcase
         end
         default:     alu_res = EX_read_data1 + alu_b;
      endcase
   end

   assign zero      = (alu_res == 8'h00);
   assign taken     = EX_Branch & (zero ^ EX_BranchFlip);
   assign br_target = EX_pcplus4 + {{14{EX_instruction[15]}}, EX_instruction[15:0], 2'b00};
   assign j_target  = {EX_pcplus4[31:28], EX_instruction[25:0], 2'b00};
   assign target    = EX_Jump ? j_target : br_target;
   assign redirect  = ~is_mult & (EX_Jump | taken);
   assign wr        = EX_RegDst ? EX_instruction[15:11] : EX_instruction[20:16];

`ifdef EX_MULT_EN
   ex_state_e  state_q, state_d;
   logic       mul_start, mul_busy, mul_done;
   logic [7:0] mul_product;

   // The mult is still presented in MUL_DONE; the state check keeps it from restarting.
   assign mul_start = (state_q == ST_IDLE) && is_mult;
   assign ex_stall  = mul_start | mul_busy;

   ex_mul8 u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .a_i       (EX_read_data1),
      .b_i       (alu_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (is_mult) state_d = ST_MUL_BUSY;
         ST_MUL_BUSY: if (mul_done) state_d = ST_MUL_DONE;
         ST_MUL_DONE: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end
`else
   assign ex_stall = 1'b0;
`endif

   logic [7:0]      res_d, wdata_d;
   logic [4:0]      wr_d;
   logic            memread_d, memwrite_d, regwrite_d, memtoreg_d, redirect_d;
   logic [PC_W-1:0] target_d;

   always_comb begin
      res_d      = alu_res;
      wdata_d    = EX_read_data2;
      wr_d       = wr;
      memread_d  = EX_MemRead;
      memwrite_d = EX_MemWrite;
      regwrite_d = EX_RegWrite;
      memtoreg_d = EX_MemtoReg;
      redirect_d = redirect;
      target_d   = target;
`ifdef EX_MULT_EN
      if (ex_stall) begin
         res_d      = 8'h00;
         wdata_d    = 8'h00;
         wr_d       = 5'd0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         redirect_d = 1'b0;
         target_d   = '0;
      end else if (state_q == ST_MUL_DONE) begin
         res_d = mul_product;
      end
`else
      if (is_mult) regwrite_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         MEM_alu_result  <= 8'h00;
         MEM_write_data  <= 8'h00;
         MEM_write_reg   <= 5'd0;
         MEM_MemRead     <= 1'b0;
         MEM_MemWrite    <= 1'b0;
         MEM_RegWrite    <= 1'b0;
         MEM_MemtoReg    <= 1'b0;
         MEM_pc_redirect <= 1'b0;
         MEM_pc_target   <= '0;
      end else begin
         MEM_alu_result  <= res_d;
         MEM_write_data  <= wdata_d;
         MEM_write_reg   <= wr_d;
         MEM_MemRead     <= memread_d;
         MEM_MemWrite    <= memwrite_d;
         MEM_RegWrite    <= regwrite_d;
         MEM_MemtoReg    <= memtoreg_d;
         MEM_pc_redirect <= redirect_d;
         MEM_pc_target   <= target_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage (vector table, random model, multiply/reset sequences).
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  EX_read_data1, EX_read_data2;
   logic [31:0] EX_instruction, EX_pcplus4;
   logic [1:0]  EX_ALUOp;
   logic        EX_ALUSrc, EX_RegDst, EX_Branch, EX_BranchFlip, EX_Jump;
   logic        EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg;
   logic        ex_stall;
   logic [7:0]  MEM_alu_result, MEM_write_data;
   logic [4:0]  MEM_write_reg;
   logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg;
   logic        MEM_pc_redirect;
   logic [31:0] MEM_pc_target;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .EX_read_data1(EX_read_data1), .EX_read_data2(EX_read_data2),
      .EX_instruction(EX_instruction), .EX_pcplus4(EX_pcplus4),
      .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
      .EX_Branch(EX_Branch), .EX_BranchFlip(EX_BranchFlip), .EX_Jump(EX_Jump),
      .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
      .ex_stall(ex_stall),
      .MEM_alu_result(MEM_alu_result), .MEM_write_data(MEM_write_data),
      .MEM_write_reg(MEM_write_reg), .MEM_MemRead(MEM_MemRead),
      .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
      .MEM_MemtoReg(MEM_MemtoReg), .MEM_pc_redirect(MEM_pc_redirect),
      .MEM_pc_target(MEM_pc_target)
   );

   // ctl = {ALUSrc, RegDst, Branch, BranchFlip, Jump, MemRead, MemWrite, RegWrite, MemtoReg}
   localparam logic [8:0] C_NONE  = 9'b000000000;
   localparam logic [8:0] C_RTYPE = 9'b010000010;
   localparam logic [8:0] C_ADDI  = 9'b100000010;
   localparam logic [8:0] C_BR    = 9'b001000000;
   localparam logic [8:0] C_BRF   = 9'b001100000;
   localparam logic [8:0] C_J     = 9'b000010000;

   typedef struct {
      string       name;
      logic [7:0]  rs, rt;
      logic [31:0] instr, pc4;
      logic [1:0]  op;
      logic [8:0]  ctl;
      logic [7:0]  e_res;
      logic [4:0]  e_wr;
      logic        e_red;
      logic [31:0] e_tgt;
      logic        e_rw;
   } vec_t;

   typedef struct {
      logic [7:0]  res;
      logic [4:0]  wr;
      logic        red;
      logic [31:0] tgt;
   } exp_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] rs, input logic [7:0] rt, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic [1:0] op, input logic [8:0] ctl);
      EX_read_data1  = rs;
      EX_read_data2  = rt;
      EX_instruction = instr;
      EX_pcplus4     = pc4;
      EX_ALUOp       = op;
      {EX_ALUSrc, EX_RegDst, EX_Branch, EX_BranchFlip, EX_Jump,
       EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg} = ctl;
   endtask

   function automatic int s8(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   function automatic exp_t model(input logic [7:0] rs, input logic [7:0] rt, input logic [31:0] instr,
                                  input logic [31:0] pc4, input logic [1:0] op, input logic [8:0] ctl);
      exp_t        m;
      int          a, b, r, imm;
      logic [31:0] off, rr;
      a = int'(rs);
      b = ctl[8] ? int'(instr[7:0]) : int'(rt);
      case (op)
         2'd1: r = a - b;
         2'd2: begin
            case (instr[5:0])
               6'h20:   r = a + b;
               6'h22:   r = a - b;
               6'h24:   r = a & b;
               6'h25:   r = a | b;
               6'h2A:   r = (s8(a) < s8(b)) ? 1 : 0;
               default: r = 0;
            endcase
         end
         default: r = a + b;
      endcase
      rr    = r;
      m.res = rr[7:0];
      m.wr  = ctl[7] ? instr[15:11] : instr[20:16];
      imm   = instr[15] ? int'(instr[15:0]) - 65536 : int'(instr[15:0]);
      off   = imm * 4;
      m.tgt = ctl[4] ? ((pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4)) : pc4 + off;
      m.red = ctl[4] | (ctl[6] & ((m.res == 8'h00) != ctl[5]));
      return m;
   endfunction

   task automatic check_zero_mem(input string nm);
      chk({nm, ".stall"}, 32'(ex_stall), 32'd0);
      chk({nm, ".res"}, 32'(MEM_alu_result), 32'd0);
      chk({nm, ".wdata"}, 32'(MEM_write_data), 32'd0);
      chk({nm, ".wreg"}, 32'(MEM_write_reg), 32'd0);
      chk({nm, ".ctrl"}, 32'({MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg}), 32'd0);
      chk({nm, ".redir"}, 32'(MEM_pc_redirect), 32'd0);
      chk({nm, ".tgt"}, MEM_pc_target, 32'd0);
   endtask

   // Multiply sequence: count stall cycles, require bubbles meanwhile, then the product.
   task automatic run_mult(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [7:0] prod);
      int  stalls = 0;
      bit  done = 0;
      int  e_stalls;
      logic [7:0] e_res;
      logic       e_rw;
`ifdef EX_MULT_EN
      e_stalls = 9; e_res = prod; e_rw = 1'b1;
`else
      e_stalls = 0; e_res = 8'h00; e_rw = 1'b0;
`endif
      drive(a, b, 32'h0000_2818, 32'h0000_0400, 2'b10, C_RTYPE);
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (ex_stall) begin
            stalls++;
            @(posedge clk); #1;
            chk({nm, ".bubble_rw"}, 32'(MEM_RegWrite), 32'd0);
            chk({nm, ".bubble_res"}, 32'(MEM_alu_result), 32'd0);
         end else begin
            @(posedge clk); #1;
            done = 1;
            drive(8'h00, 8'h00, 32'h0, 32'h0, 2'b00, C_NONE);
         end
      end
      chk({nm, ".finished"}, 32'(done), 32'd1);
      chk({nm, ".stall_cycles"}, 32'(stalls), 32'(e_stalls));
      chk({nm, ".res"}, 32'(MEM_alu_result), 32'(e_res));
      chk({nm, ".rw"}, 32'(MEM_RegWrite), 32'(e_rw));
      chk({nm, ".wreg"}, 32'(MEM_write_reg), 32'd5);
      chk({nm, ".redir"}, 32'(MEM_pc_redirect), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{"add_ovf", 8'h7F, 8'h01, 32'h0000_4820, 32'h0, 2'b10, C_RTYPE, 8'h80, 5'd9, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"beq", 8'h33, 8'h33, 32'h1000_FFFE, 32'h100, 2'b01, C_BR, 8'h00, 5'd0, 1'b1, 32'h0F8, 1'b0});
      vecs.push_back('{"beq_flip", 8'h33, 8'h33, 32'h1000_FFFE, 32'h100, 2'b01, C_BRF, 8'h00, 5'd0, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{"bne_taken", 8'h01, 8'h02, 32'h1400_0004, 32'h200, 2'b01, C_BRF, 8'hFF, 5'd0, 1'b1, 32'h210, 1'b0});
      vecs.push_back('{"jump", 8'h00, 8'h00, 32'h0800_0040, 32'h1000_0004, 2'b00, C_J, 8'h00, 5'd0, 1'b1, 32'h1000_0100, 1'b0});
      vecs.push_back('{"slt_neg", 8'hFF, 8'h01, 32'h0000_182A, 32'h0, 2'b10, C_RTYPE, 8'h01, 5'd3, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"slt_pos", 8'h01, 8'hFF, 32'h0000_182A, 32'h0, 2'b10, C_RTYPE, 8'h00, 5'd3, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"funct_undef", 8'h12, 8'h34, 32'h0000_183F, 32'h0, 2'b10, C_RTYPE, 8'h00, 5'd3, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"and", 8'hF0, 8'h3C, 32'h0000_2024, 32'h0, 2'b10, C_RTYPE, 8'h30, 5'd4, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"or", 8'hF0, 8'h0C, 32'h0000_2025, 32'h0, 2'b10, C_RTYPE, 8'hFC, 5'd4, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"sub_funct", 8'h05, 8'h07, 32'h0000_3022, 32'h0, 2'b10, C_RTYPE, 8'hFE, 5'd6, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"addi", 8'h10, 8'h99, 32'h2007_0005, 32'h0, 2'b00, C_ADDI, 8'h15, 5'd7, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{"aluop11", 8'h20, 8'h22, 32'h0000_0000, 32'h0, 2'b11, C_NONE, 8'h42, 5'd0, 1'b0, 32'h0, 1'b0});

      rst = 1'b1;
      drive(8'hAA, 8'h55, 32'h0000_4820, 32'h1234, 2'b00, C_RTYPE);
      @(posedge clk); #1;
      drive(8'h00, 8'h00, 32'h0, 32'h0, 2'b00, C_NONE);
      #1;
      check_zero_mem("reset");
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].instr, vecs[i].pc4, vecs[i].op, vecs[i].ctl);
         #1;
         chk({vecs[i].name, ".stall"}, 32'(ex_stall), 32'd0);
         @(posedge clk); #1;
         chk({vecs[i].name, ".res"}, 32'(MEM_alu_result), 32'(vecs[i].e_res));
         chk({vecs[i].name, ".wreg"}, 32'(MEM_write_reg), 32'(vecs[i].e_wr));
         chk({vecs[i].name, ".redir"}, 32'(MEM_pc_redirect), 32'(vecs[i].e_red));
         if (vecs[i].e_red) chk({vecs[i].name, ".tgt"}, MEM_pc_target, vecs[i].e_tgt);
         chk({vecs[i].name, ".rw"}, 32'(MEM_RegWrite), 32'(vecs[i].e_rw));
         chk({vecs[i].name, ".wdata"}, 32'(MEM_write_data), 32'(vecs[i].rt));
      end

      for (int n = 0; n < 200; n++) begin
         logic [7:0]  rs, rt;
         logic [31:0] instr, pc4;
         logic [1:0]  op;
         logic [8:0]  ctl;
         logic [5:0]  fsel[6];
         exp_t        m;
         rs    = 8'($urandom);
         rt    = 8'($urandom);
         instr = $urandom;
         pc4   = $urandom;
         op    = 2'($urandom_range(0, 3));
         ctl   = 9'($urandom);
         fsel  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'($urandom)};
         instr[5:0] = fsel[$urandom_range(0, 5)];
         if (instr[5:0] == 6'h18) instr[5:0] = 6'h20;
         m = model(rs, rt, instr, pc4, op, ctl);
         drive(rs, rt, instr, pc4, op, ctl);
         #1;
         chk("rnd.stall", 32'(ex_stall), 32'd0);
         @(posedge clk); #1;
         chk("rnd.res", 32'(MEM_alu_result), 32'(m.res));
         chk("rnd.wreg", 32'(MEM_write_reg), 32'(m.wr));
         chk("rnd.redir", 32'(MEM_pc_redirect), 32'(m.red));
         if (m.red) chk("rnd.tgt", MEM_pc_target, m.tgt);
         chk("rnd.wdata", 32'(MEM_write_data), 32'(rt));
         chk("rnd.ctrl", 32'({MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg}), 32'(ctl[3:0]));
      end

      run_mult("mul_13x11", 8'd13, 8'd11, 8'h8F);
      run_mult("mul_16x16", 8'h10, 8'h10, 8'h00);
      run_mult("mul_ffxff", 8'hFF, 8'hFF, 8'h01);

      // Reset arriving in the 4th busy cycle abandons the multiply.
      drive(8'd13, 8'd11, 32'h0000_2818, 32'h0000_0400, 2'b10, C_RTYPE);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      drive(8'd2, 8'd3, 32'h0000_4820, 32'h0, 2'b10, C_RTYPE);
      @(posedge clk); #1;
      check_zero_mem("mid_mul_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_add.res", 32'(MEM_alu_result), 32'h05);
      chk("post_reset_add.rw", 32'(MEM_RegWrite), 32'd1);
      chk("post_reset_add.wreg", 32'(MEM_write_reg), 32'd9);
      chk("post_reset_add.stall", 32'(ex_stall), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined core; the consuming end of the ID/EX pipeline interface.
- Takes the EX_* operands, instruction and control bits and computes the ALU result, destination register and branch/jump redirect.
- Registers the results into the EX/MEM boundary.
- Adds an iterative 8-bit multiplier; a stall output holds the upstream stages while it runs.

Parameters:
- MUL_CYCLES, 8, shift-add iterations per multiply; fixed equal to operand width.
- PC_W, 32, width of PC, branch target and jump target.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- EX_read_data1  in  8  rs operand
- EX_read_data2  in  8  rt operand / store data
- EX_instruction  in  32  MIPS-format instruction word
- EX_pcplus4  in  32  PC+4 of the instruction
- EX_ALUOp  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 reserved (treated as add)
- EX_ALUSrc, EX_RegDst, EX_Branch, EX_BranchFlip, EX_Jump  in  1 each  EX controls
- EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg  in  1 each  pass-through controls
- ex_stall  out  1  hold IF/ID and ID/EX this cycle
- MEM_alu_result  out  8  registered ALU/multiply result
- MEM_write_data  out  8  registered EX_read_data2
- MEM_write_reg  out  5  registered destination register
- MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg  out  1 each  registered controls
- MEM_pc_redirect  out  1  registered taken branch or jump
- MEM_pc_target  out  32  registered redirect target

Behaviour:
- Synchronous active-high reset, one clock (clk, rst). Reset drives all MEM_* outputs to 0, FSM to IDLE, ex_stall to 0. Reset mid-multiply abandons the operation; no result is written.
- Immediate: instruction[15:0] sign-extended; the ALU uses the low 8 bits when EX_ALUSrc=1, otherwise EX_read_data2.
- ALU (8-bit, carry discarded):
  - ALUOp 00 add; 01 sub.
  - ALUOp 10 funct[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0x01/0x00), 0x18 mult (low 8 bits of the product). Any other funct gives result 0.
- zero = (ALU result == 0).
- Branch taken = EX_Branch & (zero ^ EX_BranchFlip).
- Branch target = EX_pcplus4 + (sext(imm) << 2), mod 2^32.
- Jump target = {EX_pcplus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
- write_reg = EX_RegDst ? instr[15:11] : instr[20:16].
- Single-cycle ops: every posedge with ex_stall=0 registers all MEM_* outputs. Latency is 1 cycle.
- FSM: IDLE, MUL_BUSY, MUL_DONE.
  - IDLE: if ALUOp=10 and funct=0x18, ex_stall=1 (combinational, same cycle). On that edge, latch operands, count=0, go to MUL_BUSY. MEM_* takes a bubble: all control bits and MEM_pc_redirect 0, data fields 0.
  - MUL_BUSY: ex_stall=1. Each cycle, add (multiplicand << count) when multiplier bit[count]=1. Increment count. After MUL_CYCLES iterations go to MUL_DONE. A bubble is written every cycle.
  - MUL_DONE: ex_stall=0. The product's low byte and the instruction's controls are registered to MEM. Return to IDLE; no re-detection of the still-present mult.
- Multiply total: 10 cycles from first presentation to MEM write; ex_stall is high for exactly 9 cycles.
- Multiply never redirects the PC.

Optional Feature:
- EX_MULT_EN defined: multiplier, FSM and stall as above.
- EX_MULT_EN undefined: no FSM or multiplier; ex_stall tied 0. funct 0x18 yields result 0 with MEM_RegWrite forced 0 (behaves as a NOP).

Decomposition:
- Package ex_pkg holds:
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE).
  - Funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_MULT).
  - FSM state typedef.
- One sub-module, ex_mul8: iterative shift-add multiplier with start/busy/done.

Test Plan:
- add, rs=0x7F, rt=0x01, rd=9, RegDst=1, RegWrite=1 -> next edge MEM_alu_result=0x80, MEM_write_reg=9, MEM_RegWrite=1, ex_stall=0.
- beq, rs=rt=0x33, imm=0xFFFE, pcplus4=0x100 -> MEM_pc_redirect=1, MEM_pc_target=0x0F8. Same with BranchFlip=1 -> redirect=0.
- j, instr[25:0]=0x0000040, pcplus4=0x1000_0004 -> MEM_pc_target=0x1000_0100, redirect=1.
- mult 13*11 -> ex_stall high 9 cycles, bubbles (MEM_RegWrite=0) meanwhile, then MEM_alu_result=0x8F, MEM_RegWrite=1. Also 0x10*0x10 -> 0x00.
- rst asserted in the 4th MUL_BUSY cycle -> next edge ex_stall=0, all MEM_* = 0. Then add 2+3 -> 0x05 one cycle later.
- slt, rs=0xFF(-1), rt=0x01 -> 0x01; undefined funct 0x3F -> 0x00.
